oam_dma_arbiter: RTL and testbench
==================================

Name: oam_dma_arbiter

Overview:
- Shares the cpu6502 external memory bus between the CPU and a 256-byte page-copy DMA engine, in the style of NES sprite DMA.
- A CPU store to TRIGGER_ADDR latches a source page, halts the CPU via cpu_rdy, and copies $pp00–$ppFF to DEST_ADDR one byte per read/write cycle pair.
- Sits between cpu6502 and rom/ram. Its bus mux passes the CPU through when the DMA does not own the bus.

Parameters:
- TRIGGER_ADDR, 16'h4014, CPU write address that starts a transfer.
- DEST_ADDR, 16'h2004, fixed destination address for every byte written.
- LENGTH, 256, bytes per transfer; must be 1..256.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cyc_en  in  1  one-clk strobe marking the end of each CPU bus cycle (falling edge of clk2)
- cpu_addr  in  16  CPU address
- cpu_odata  in  8  CPU write data
- cpu_rw  in  1  CPU read(1)/write(0)
- mem_idata  in  8  memory read data; also routed to the CPU unchanged
- bus_addr  out  16  muxed bus address
- bus_odata  out  8  muxed bus write data
- bus_rw  out  1  muxed bus read/write
- cpu_rdy  out  1  0 = CPU held
- dma_busy  out  1  1 while any state other than IDLE is active

Behaviour:
- Reset values (asynchronous):
  - state=IDLE, cpu_rdy=1, dma_busy=0.
  - page=0, idx=0, data=0, parity=0.
  - Bus outputs pass through the CPU.
- All state changes occur only on clk edges where cyc_en=1. parity toggles on every cyc_en.
- IDLE:
  - On cyc_en with cpu_addr==TRIGGER_ADDR and cpu_rw==0: page<=cpu_odata, idx<=0, go to HALT.
  - The trigger write itself completes normally on the bus.
- HALT:
  - cpu_rdy=0, bus passes through the CPU.
  - On cyc_en with cpu_rw==1 (6502 honours RDY only on reads), go to ALIGN if parity==1, else READ.
  - If cpu_rw==0 (CPU completing back-to-back writes), stay in HALT.
- ALIGN:
  - Lasts one cycle. cpu_rdy=0, bus passes through the CPU with bus_rw forced to 1.
  - Next cycle is READ.
- READ:
  - bus_addr={page,idx[7:0]}, bus_rw=1.
  - On cyc_en: data<=mem_idata, go to WRITE.
- WRITE:
  - bus_addr=DEST_ADDR, bus_odata=data, bus_rw=0.
  - On cyc_en: if idx==LENGTH-1, go to IDLE; else idx<=idx+1 and go to READ.
- cpu_rdy returns to 1 in the same clk that IDLE is entered. dma_busy=(state!=IDLE).
- Latency from the trigger cycle's cyc_en to the return to IDLE is 1 + (0|1) + 2*LENGTH CPU cycles: 513 or 514 for LENGTH=256, plus any extra HALT cycles spent waiting on CPU writes.
- idx is 9 bits and compared against LENGTH-1, so there is no 8-bit wrap ambiguity. The source address never crosses the page ($ppFF is the last byte).
- Writes to TRIGGER_ADDR while not in IDLE are ignored. They cannot normally occur, because the CPU is halted.
- A trigger write with cpu_odata=8'h00 copies page 0. There is no special case for it.
- Reset asserted mid-transfer:
  - Immediate return to IDLE and cpu_rdy=1.
  - Partial writes already performed stay in memory; no resume.
- In IDLE and HALT, bus outputs are combinationally equal to the CPU inputs.
- mem_idata reaches the CPU regardless of state. The CPU ignores it while cpu_rdy=0.

Test Plan:
- Fill page $02 with byte i at $02ii. CPU executes LDA #$02; STA $4014. Expect:
  - 256 writes to $2004 carrying $00..$FF in order.
  - cpu_rdy low for 513 or 514 cyc_en strobes, depending on parity.
  - The next instruction's fetch follows the low period.
- Force the trigger so HALT exits with parity=0: exactly 513 cycles with rdy low, no ALIGN. Force parity=1: exactly 514 cycles, with one ALIGN cycle showing bus_rw=1 and no write.
- HALT entered while the CPU is in a write cycle (trigger followed by a second write): HALT lasts 2 cycles. The first READ is to $pp00 only after a cyc_en with cpu_rw=1.
- Assert reset at byte 100 (idx=100, state WRITE). Expect:
  - Outputs return to reset values asynchronously.
  - $2004 has received exactly 100 or 101 writes.
  - A new trigger later restarts from $pp00.
- Write to $4015 and do a read of $4014: no transfer, cpu_rdy stays 1, and the bus is a pure passthrough (bus_addr=cpu_addr every cycle).
- Instance with LENGTH=1, trigger page $80: exactly one read of $8000 and one write to $2004, then IDLE. Total rdy-low time is 3 or 4 cycles.

Source files
------------

// File: rtl/oam_dma_arbiter.sv
// OAM-style page DMA: halts the 6502 and copies one page to a fixed port.
// Bus mux passes the CPU through whenever the DMA does not own the bus.
module oam_dma_arbiter #(
  parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
  parameter logic [15:0] DEST_ADDR    = 16'h2004,
  parameter int          LENGTH       = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cyc_en,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_odata,
  input  logic        cpu_rw,
  input  logic [7:0]  mem_idata,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_odata,
  output logic        bus_rw,
  output logic        cpu_rdy,
  output logic        dma_busy
);

  typedef enum logic [2:0] {
    IDLE, HALT, ALIGN, READ, WRITE
  } state_t;

  localparam logic [8:0] LAST = 9'(LENGTH - 1);

  state_t     state, state_nx;
  logic [7:0] page;
  logic [7:0] data;
  logic [8:0] idx;
  logic       parity;
  logic       trig;

  assign trig = (cpu_addr == TRIGGER_ADDR) && !cpu_rw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      page   <= '0;
      data   <= '0;
      idx    <= '0;
      parity <= 1'b0;
    end else if (cyc_en) begin
      parity <= ~parity;
      state  <= state_nx;
      unique case (state)
        IDLE: if (trig) begin
          page <= cpu_odata;
          idx  <= '0;
        end
        READ:  data <= mem_idata;
        WRITE: if (idx != LAST) idx <= idx + 9'd1;
        default: ;
      endcase
    end
  end

  // ALIGN forces a read so the CPU cannot write while parity is fixed up
  always_comb begin
    state_nx  = state;
    bus_addr  = cpu_addr;
    bus_odata = cpu_odata;
    bus_rw    = cpu_rw;
    cpu_rdy   = 1'b0;
    unique case (state)
      IDLE: begin
        cpu_rdy = 1'b1;
        if (trig) state_nx = HALT;
      end
      HALT: begin
        if (cpu_rw) state_nx = parity ? ALIGN : READ;
      end
      ALIGN: begin
        bus_rw   = 1'b1;
        state_nx = READ;
      end
      READ: begin
        bus_addr = {page, idx[7:0]};
        bus_rw   = 1'b1;
        state_nx = WRITE;
      end
      WRITE: begin
        bus_addr  = DEST_ADDR;
        bus_odata = data;
        bus_rw    = 1'b0;
        state_nx  = (idx == LAST) ? IDLE : READ;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign dma_busy = (state != IDLE);

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Random-timing bench: two instances (256-byte and 1-byte) share one CPU.
// Transfers are checked against counts and bytes derived from memory.
module tb_oam_dma_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cyc_en;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_odata;
  logic        cpu_rw;

  logic [15:0] ba_a, ba_b;
  logic [7:0]  bo_a, bo_b, mi_a, mi_b;
  logic        rw_a, rw_b, rdy_a, rdy_b, busy_a, busy_b;

  logic [7:0]  mem [0:65535];

  assign mi_a = mem[ba_a];
  assign mi_b = mem[ba_b];

  always #5 clk = ~clk;

  oam_dma_arbiter u_a (
    .clk(clk), .reset(reset), .cyc_en(cyc_en),
    .cpu_addr(cpu_addr), .cpu_odata(cpu_odata),
    .cpu_rw(cpu_rw), .mem_idata(mi_a),
    .bus_addr(ba_a), .bus_odata(bo_a), .bus_rw(rw_a),
    .cpu_rdy(rdy_a), .dma_busy(busy_a)
  );

  oam_dma_arbiter #(.LENGTH(1)) u_b (
    .clk(clk), .reset(reset), .cyc_en(cyc_en),
    .cpu_addr(cpu_addr), .cpu_odata(cpu_odata),
    .cpu_rw(cpu_rw), .mem_idata(mi_b),
    .bus_addr(ba_b), .bus_odata(bo_b), .bus_rw(rw_b),
    .cpu_rdy(rdy_b), .dma_busy(busy_b)
  );

  int vectors = 0;
  int errs = 0;
  int nstrobe = 0;
  int nlow [2];
  int nwr [2];
  int nrd [2];
  int nstray [2];
  logic [7:0]  wlog [2][256];
  logic [15:0] rd0 [2];
  bit post;

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic obs(input int u, input logic [15:0] ba,
                     input logic [7:0] bo, input logic rw,
                     input logic rdy, input logic busy);
    if (!rdy) nlow[u]++;
    if (busy && !rw && ba == 16'h2004) begin
      if (nwr[u] < 256) wlog[u][nwr[u]] = bo;
      nwr[u]++;
    end else if (busy && !rw && post) begin
      nstray[u]++;
    end
    if (busy && rw && ba != cpu_addr) begin
      if (nrd[u] == 0) rd0[u] = ba;
      nrd[u]++;
    end
  endtask

  task automatic cycle(input logic [15:0] ad, input logic rw,
                       input logic [7:0] d);
    cpu_addr  = ad;
    cpu_rw    = rw;
    cpu_odata = d;
    cyc_en    = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    cyc_en = 1'b1;
    #1;
    obs(0, ba_a, bo_a, rw_a, rdy_a, busy_a);
    obs(1, ba_b, bo_b, rw_b, rdy_b, busy_b);
    @(negedge clk);
    cyc_en = 1'b0;
    nstrobe++;
  endtask

  task automatic clr();
    for (int u = 0; u < 2; u++) begin
      nlow[u] = 0; nwr[u] = 0; nrd[u] = 0;
      nstray[u] = 0; rd0[u] = 16'hFFFF;
    end
    post = 1'b0;
  endtask

  // trigger, k extra CPU writes, then reads until the copy ends
  task automatic start(input logic [7:0] pg, input int k,
                       input int par, output int h);
    if (((nstrobe + 1 + k) & 1) != par) cycle(16'hC000, 1'b1, 8'hEA);
    clr();
    h = nstrobe + 1 + k;
    cycle(16'h4014, 1'b0, pg);
    for (int i = 0; i < k; i++)
      cycle(16'h0300 + 16'(i), 1'b0, 8'($urandom));
    cycle(16'hC000, 1'b1, 8'h00);
    post = 1'b1;
  endtask

  task automatic xfer(input logic [7:0] pg, input int k, input int par);
    int h, n, len;
    start(pg, k, par, h);
    n = 0;
    while ((rdy_a === 1'b0 || busy_a === 1'b1) && n < 1200) begin
      cycle(16'hC000, 1'($urandom_range(0, 1)), 8'($urandom));
      n++;
    end
    chk("done in budget", int'(n < 1200), 1);
    for (int u = 0; u < 2; u++) begin
      len = (u == 0) ? 256 : 1;
      chk("rdy low count", nlow[u], 1 + k + (h & 1) + 2 * len);
      chk("write count", nwr[u], len);
      chk("read count", nrd[u], len);
      chk("first read", int'(rd0[u]), int'({pg, 8'h00}));
      chk("stray writes", nstray[u], 0);
      for (int i = 0; i < len; i++)
        chk("copied byte", int'(wlog[u][i]),
            int'(mem[{pg, 8'(i)}]));
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " addr a"}, int'(ba_a), int'(cpu_addr));
    chk({tag, " addr b"}, int'(ba_b), int'(cpu_addr));
    chk({tag, " rw"}, int'(rw_a), int'(cpu_rw));
    chk({tag, " odata"}, int'(bo_a), int'(cpu_odata));
    chk({tag, " rdy"}, int'({rdy_a, rdy_b}), 3);
    chk({tag, " busy"}, int'({busy_a, busy_b}), 0);
  endtask

  initial begin
    int h, n;
    logic [15:0] ad;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + 16'(i)] = 8'(i);
    clr();
    reset = 1'b1; cyc_en = 1'b0;
    cpu_addr = 16'h1234; cpu_rw = 1'b1; cpu_odata = 8'h5A;
    #1;
    chk_idle("reset");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    nstrobe = 0;

    for (int i = 0; i < 24; i++) begin
      case (i % 3)
        0: cycle(16'h4015, 1'b0, 8'($urandom));
        1: cycle(16'h4014, 1'b1, 8'($urandom));
        default: begin
          ad = 16'($urandom);
          if (ad == 16'h4014) ad = 16'h4016;
          cycle(ad, 1'($urandom_range(0, 1)), 8'($urandom));
        end
      endcase
      chk_idle("passthru");
    end

    xfer(8'h02, 0, 0);
    xfer(8'h02, 0, 1);
    xfer(8'h80, 0, int'($urandom_range(0, 1)));
    xfer(8'($urandom_range(8'h10, 8'hBF)), 1, 0);
    xfer(8'h00, 1, 1);

    start(8'h55, 0, 0, h);
    n = 0;
    while (nwr[0] < 100 && n < 600) begin
      cycle(16'hC000, 1'b1, 8'h00);
      n++;
    end
    cycle(16'hC000, 1'b1, 8'h00);
    #1;
    chk("pre-reset write", int'({rw_a, ba_a}), int'({1'b0, 16'h2004}));
    reset = 1'b1;
    #1;
    chk_idle("async reset");
    chk("partial writes", int'(nwr[0] == 100 || nwr[0] == 101), 1);
    @(negedge clk);
    reset = 1'b0;
    nstrobe = 0;
    xfer(8'h55, 0, int'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
